// File: rtl/axis_packetizer.sv
// ---------------------------------------------------------------------------
// axis_packetizer
//
// Frames a continuous AXI4-Stream of samples into fixed-length packets and
// marks the final beat of each packet with M_AXIS_tlast. The result feeds a
// DMA / RAM-writer stage.
//
// Datapath: one output register plus a one-entry skid register. Every output
// comes straight from a flop. S_AXIS_tready is registered too. The skid entry
// catches the single beat that can arrive in the cycle when the master side
// first stalls. Because of it, a full 1 beat/cycle rate holds while
// M_AXIS_tready stays high, and no beat is lost or duplicated under
// backpressure.
//
// Framing: a three-state FSM (IDLE / RUN / STOP) gates acceptance.
// cfg_length is captured only at a packet start, so a change never affects a
// packet that is already under way. Dropping enable always lets the current
// packet finish before acceptance stops. tlast is decided when a beat is
// accepted and then travels with its data through both registers.
//
// Ports:
//   aclk           in   clock, rising edge
//   aresetn        in   synchronous active-low reset
//   enable         in   1 = start/continue packetizing, 0 = stop after packet
//   cfg_length     in   beats per packet, sampled at each packet start
//   S_AXIS_tready  out  slave ready (registered)
//   S_AXIS_tvalid  in   slave valid
//   S_AXIS_tdata   in   slave data
//   M_AXIS_tready  in   master ready
//   M_AXIS_tvalid  out  master valid
//   M_AXIS_tdata   out  master data
//   M_AXIS_tlast   out  last beat of packet
//   packet_count   out  packets fully transferred on the master side
// ---------------------------------------------------------------------------
module axis_packetizer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int LENGTH_WIDTH     = 16,
    parameter int COUNT_WIDTH      = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic [LENGTH_WIDTH-1:0]     cfg_length,
    output logic                        S_AXIS_tready,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tlast,
    output logic [COUNT_WIDTH-1:0]      packet_count
);

    localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t                        r_state;
    logic [LENGTH_WIDTH-1:0]       r_len;       // beats in the current packet
    logic [LENGTH_WIDTH-1:0]       r_cnt;       // beats accepted so far
    logic                          r_s_tready;
    logic                          r_m_valid;
    logic [AXIS_TDATA_WIDTH-1:0]   r_m_data;
    logic                          r_m_last;
    logic                          r_sk_valid;
    logic [AXIS_TDATA_WIDTH-1:0]   r_sk_data;
    logic                          r_sk_last;
    logic [COUNT_WIDTH-1:0]        r_pkt_cnt;

    // ---------------------------------------------------------------------
    // Wires
    // ---------------------------------------------------------------------
    state_t                        w_state_nxt;
    logic                          w_s_fire;
    logic                          w_m_fire;
    logic                          w_out_free;
    logic                          w_is_last;
    logic                          w_boundary;
    logic                          w_start;
    logic                          w_permit_nxt;
    logic                          w_m_valid_nxt;
    logic [AXIS_TDATA_WIDTH-1:0]   w_m_data_nxt;
    logic                          w_m_last_nxt;
    logic                          w_sk_valid_nxt;
    logic [AXIS_TDATA_WIDTH-1:0]   w_sk_data_nxt;
    logic                          w_sk_last_nxt;
    logic                          w_s_tready_nxt;

    assign w_s_fire   = S_AXIS_tvalid & r_s_tready;
    assign w_m_fire   = r_m_valid & M_AXIS_tready;
    // The output register can take a new beat this cycle if it is empty now
    // or if its current beat leaves this cycle.
    assign w_out_free = ~r_m_valid | M_AXIS_tready;
    // r_len is never 0 while beats are accepted, so len-1 cannot underflow
    // in any cycle where this matters.
    assign w_is_last  = (r_cnt == (r_len - LEN_ONE));
    assign w_boundary = w_s_fire & w_is_last;

    // ---------------------------------------------------------------------
    // FSM process 1: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, and reset is
    // sampled on the clock edge, so reset behaves like any other
    // synchronous input.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable && (cfg_length != '0)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_boundary) begin
                    // A packet just closed. Stop cleanly if enable fell or
                    // if the next packet would have zero length.
                    if (!enable || (cfg_length == '0)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!enable) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finish the packet. A re-asserted enable is ignored here
                // and takes effect from IDLE.
                if (w_boundary) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM process 3: state-derived controls
    // ---------------------------------------------------------------------
    always_comb begin
        w_permit_nxt = (w_state_nxt != ST_IDLE);
        w_start      = (r_state == ST_IDLE) && (w_state_nxt == ST_RUN);
    end

    // ---------------------------------------------------------------------
    // Packet length / beat counter
    // ---------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_start) begin
            r_len <= cfg_length;
            r_cnt <= '0;
        end else if (w_s_fire) begin
            if (w_is_last) begin
                // Re-latch here so a new cfg_length applies only from the
                // next packet onward.
                r_cnt <= '0;
                r_len <= cfg_length;
            end else begin
                r_cnt <= r_cnt + LEN_ONE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output register + skid register next-state
    // ---------------------------------------------------------------------
    always_comb begin
        w_m_valid_nxt  = r_m_valid;
        w_m_data_nxt   = r_m_data;
        w_m_last_nxt   = r_m_last;
        w_sk_valid_nxt = r_sk_valid;
        w_sk_data_nxt  = r_sk_data;
        w_sk_last_nxt  = r_sk_last;

        if (w_out_free) begin
            if (r_sk_valid) begin
                // The older beat in the skid entry goes out first, which
                // keeps beats in order.
                w_m_valid_nxt = 1'b1;
                w_m_data_nxt  = r_sk_data;
                w_m_last_nxt  = r_sk_last;
                if (w_s_fire) begin
                    w_sk_data_nxt = S_AXIS_tdata;
                    w_sk_last_nxt = w_is_last;
                end else begin
                    w_sk_valid_nxt = 1'b0;
                end
            end else if (w_s_fire) begin
                w_m_valid_nxt = 1'b1;
                w_m_data_nxt  = S_AXIS_tdata;
                w_m_last_nxt  = w_is_last;
            end else begin
                w_m_valid_nxt = 1'b0;
            end
        end else if (w_s_fire) begin
            // The master is stalled. S_AXIS_tready was still high this
            // cycle, so this beat lands in the (empty) skid entry.
            w_sk_valid_nxt = 1'b1;
            w_sk_data_nxt  = S_AXIS_tdata;
            w_sk_last_nxt  = w_is_last;
        end

        // Accept next cycle only while the FSM allows it and the skid entry
        // can still absorb one beat if the master stalls.
        w_s_tready_nxt = w_permit_nxt & ~w_sk_valid_nxt;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_s_tready <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_last  <= 1'b0;
        end else begin
            r_s_tready <= w_s_tready_nxt;
            r_m_valid  <= w_m_valid_nxt;
            r_m_data   <= w_m_data_nxt;
            r_m_last   <= w_m_last_nxt;
            r_sk_valid <= w_sk_valid_nxt;
            r_sk_data  <= w_sk_data_nxt;
            r_sk_last  <= w_sk_last_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Completed-packet counter (wraps naturally)
    // ---------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_pkt_cnt <= '0;
        end else if (w_m_fire && r_m_last) begin
            r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
        end
    end

    assign S_AXIS_tready = r_s_tready;
    assign M_AXIS_tvalid = r_m_valid;
    assign M_AXIS_tdata  = r_m_data;
    assign M_AXIS_tlast  = r_m_last;
    assign packet_count  = r_pkt_cnt;

endmodule

// File: tb/tb_axis_packetizer.sv
// ---------------------------------------------------------------------------
// tb_axis_packetizer
//
// Self-checking bench for axis_packetizer.
// - A directed table walks through reset, zero length, length 1 with
//   enable falling on a boundary, and one skid-register stall.
// - Stream sequences cover:
//     * back-to-back framing with cfg_length = 4
//     * random backpressure with cfg_length = 5
//     * stopping mid-packet
//     * a cfg_length change in the middle of a packet
//     * reset in the middle of a packet while the master is stalled
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_axis_packetizer;

    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [15:0] cfg_length;
    logic        S_AXIS_tready;
    logic        S_AXIS_tvalid;
    logic [31:0] S_AXIS_tdata;
    logic        M_AXIS_tready;
    logic        M_AXIS_tvalid;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tlast;
    logic [31:0] packet_count;

    int n_checks = 0;
    int n_fail   = 0;

    axis_packetizer #(
        .AXIS_TDATA_WIDTH (32),
        .LENGTH_WIDTH     (16),
        .COUNT_WIDTH      (32)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .cfg_length    (cfg_length),
        .S_AXIS_tready (S_AXIS_tready),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .packet_count  (packet_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One directed step: the inputs applied before an edge, and the outputs
    // expected just after that edge.
    typedef struct packed {
        logic        en;
        logic [15:0] cfg;
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        e_tr;
        logic        e_mv;
        logic [31:0] e_d;
        logic        e_l;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reset for one edge, then confirm every output is cleared.
    task automatic do_reset();
        aresetn       = 1'b0;
        enable        = 1'b0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata  = '0;
        tick();
        check("rst_s_tready", 32'(S_AXIS_tready), 32'd0);
        check("rst_m_tvalid", 32'(M_AXIS_tvalid), 32'd0);
        check("rst_m_tdata",  M_AXIS_tdata,       32'd0);
        check("rst_m_tlast",  32'(M_AXIS_tlast),  32'd0);
        check("rst_pkt_cnt",  packet_count,       32'd0);
        aresetn = 1'b1;
    endtask

    // Reference framing: the first packet has first_len beats, and every
    // later packet has len beats.
    function automatic logic exp_last(input int k, input int first_len, input int len);
        if (k < first_len) return (k == first_len - 1);
        return (((k - first_len + 1) % len) == 0);
    endfunction

    // Drive an incrementing source (base, base+1, ...) of up to `limit`
    // beats and check every master transfer against the reference framing.
    // Stops `extra` cycles after `target` beats have come out, or at the
    // cycle budget.
    task automatic run_stream(
        input  int          base,
        input  int          limit,
        input  int          target,
        input  int          first_len,
        input  int          len,
        input  bit          rand_ready,
        input  int          drop_en_at,
        input  int          chg_cfg_at,
        input  logic [15:0] new_cfg,
        input  bit          timing_chk,
        input  int          extra,
        output int          sent_o
    );
        int          sent       = 0;
        int          rcv        = 0;
        int          cyc        = 0;
        int          extra_left = extra;
        int          last_out   = -1;
        int          first_acc  = -1;
        int          first_mv   = -1;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_d     = '0;
        logic        prev_l     = 1'b0;
        bit          s_fire;
        bit          m_fire;
        while ((cyc < 20000) && (extra_left > 0)) begin
            if (prev_stall) begin
                check("hold_tdata", M_AXIS_tdata, prev_d);
                check("hold_tlast", 32'(M_AXIS_tlast), 32'(prev_l));
            end
            if (timing_chk && (first_mv < 0) && M_AXIS_tvalid) first_mv = cyc;
            enable = (drop_en_at < 0) || (sent < drop_en_at);
            if ((chg_cfg_at >= 0) && (sent >= chg_cfg_at)) cfg_length = new_cfg;
            S_AXIS_tvalid = (sent < limit);
            S_AXIS_tdata  = 32'(base + sent);
            M_AXIS_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            s_fire = S_AXIS_tvalid && S_AXIS_tready;
            m_fire = M_AXIS_tvalid && M_AXIS_tready;
            if (m_fire) begin
                check("out_tdata", M_AXIS_tdata, 32'(base + rcv));
                check("out_tlast", 32'(M_AXIS_tlast), 32'(exp_last(rcv, first_len, len)));
                if (timing_chk && (rcv > 0)) check("out_b2b_cycle", 32'(cyc), 32'(last_out + 1));
                last_out = cyc;
                rcv++;
            end
            if (s_fire) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            prev_stall = M_AXIS_tvalid && !M_AXIS_tready;
            prev_d     = M_AXIS_tdata;
            prev_l     = M_AXIS_tlast;
            if (rcv >= target) extra_left--;
            cyc++;
            tick();
        end
        check("beats_out", 32'(rcv), 32'(target));
        if (timing_chk) check("first_latency", 32'(first_mv), 32'(first_acc + 1));
        S_AXIS_tvalid = 1'b0;
        sent_o = sent;
    endtask

    initial begin
        int sent;

        aresetn       = 1'b0;
        enable        = 1'b0;
        cfg_length    = '0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata  = '0;
        M_AXIS_tready = 1'b0;
        tick();

        // ---------------- directed table ----------------
        //            en   cfg    sv   sd            mr    tr   mv   d             l     cnt
        vecs[0]  = '{1'b1, 16'd0, 1'b1, 32'h0000_00A0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd0};
        vecs[1]  = '{1'b1, 16'd0, 1'b1, 32'h0000_00A1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd0};
        vecs[2]  = '{1'b1, 16'd0, 1'b1, 32'h0000_00A2, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd0};
        vecs[3]  = '{1'b1, 16'd1, 1'b1, 32'h0000_00B0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
        vecs[4]  = '{1'b1, 16'd1, 1'b1, 32'h0000_00B1, 1'b1, 1'b1, 1'b1, 32'h0000_00B1, 1'b1, 32'd0};
        vecs[5]  = '{1'b1, 16'd1, 1'b1, 32'h0000_00B2, 1'b1, 1'b1, 1'b1, 32'h0000_00B2, 1'b1, 32'd1};
        vecs[6]  = '{1'b0, 16'd1, 1'b1, 32'h0000_00B3, 1'b1, 1'b0, 1'b1, 32'h0000_00B3, 1'b1, 32'd2};
        vecs[7]  = '{1'b0, 16'd1, 1'b1, 32'h0000_00B4, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd3};
        vecs[8]  = '{1'b0, 16'd1, 1'b0, 32'h0000_00B5, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd3};
        vecs[9]  = '{1'b1, 16'd1, 1'b1, 32'h0000_00C0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'd3};
        vecs[10] = '{1'b1, 16'd1, 1'b1, 32'h0000_00C1, 1'b0, 1'b1, 1'b1, 32'h0000_00C1, 1'b1, 32'd3};
        vecs[11] = '{1'b1, 16'd1, 1'b1, 32'h0000_00C2, 1'b0, 1'b0, 1'b1, 32'h0000_00C1, 1'b1, 32'd3};
        vecs[12] = '{1'b1, 16'd1, 1'b1, 32'h0000_00C3, 1'b0, 1'b0, 1'b1, 32'h0000_00C1, 1'b1, 32'd3};
        vecs[13] = '{1'b1, 16'd1, 1'b1, 32'h0000_00C3, 1'b1, 1'b1, 1'b1, 32'h0000_00C2, 1'b1, 32'd4};
        vecs[14] = '{1'b1, 16'd1, 1'b1, 32'h0000_00C3, 1'b1, 1'b1, 1'b1, 32'h0000_00C3, 1'b1, 32'd5};

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            enable        = vecs[i].en;
            cfg_length    = vecs[i].cfg;
            S_AXIS_tvalid = vecs[i].sv;
            S_AXIS_tdata  = vecs[i].sd;
            M_AXIS_tready = vecs[i].mr;
            tick();
            check($sformatf("vec%0d_s_tready", i), 32'(S_AXIS_tready), 32'(vecs[i].e_tr));
            check($sformatf("vec%0d_m_tvalid", i), 32'(M_AXIS_tvalid), 32'(vecs[i].e_mv));
            check($sformatf("vec%0d_pkt_cnt", i), packet_count, vecs[i].e_cnt);
            if (vecs[i].e_mv) begin
                check($sformatf("vec%0d_m_tdata", i), M_AXIS_tdata, vecs[i].e_d);
                check($sformatf("vec%0d_m_tlast", i), 32'(M_AXIS_tlast), 32'(vecs[i].e_l));
            end
        end

        // ---------------- cfg_length=4, full rate ----------------
        do_reset();
        cfg_length = 16'd4;
        run_stream(0, 8, 8, 4, 4, 1'b0, -1, -1, 16'd0, 1'b1, 3, sent);
        check("len4_pkt_cnt", packet_count, 32'd2);

        // ---------------- cfg_length=5, random backpressure ----------------
        do_reset();
        cfg_length = 16'd5;
        run_stream(0, 1000, 1000, 5, 5, 1'b1, -1, -1, 16'd0, 1'b0, 3, sent);
        check("bp_pkt_cnt", packet_count, 32'd200);

        // ---------------- enable dropped mid third packet ----------------
        do_reset();
        cfg_length = 16'd4;
        run_stream(0, 100, 12, 4, 4, 1'b0, 10, -1, 16'd0, 1'b0, 20, sent);
        check("stop_beats_in", 32'(sent), 32'd12);
        check("stop_s_tready", 32'(S_AXIS_tready), 32'd0);
        check("stop_m_tvalid", 32'(M_AXIS_tvalid), 32'd0);
        check("stop_pkt_cnt", packet_count, 32'd3);

        // ---------------- cfg_length 4 -> 2 inside the first packet ----------------
        do_reset();
        cfg_length = 16'd4;
        run_stream(32'h400, 10, 10, 4, 2, 1'b0, -1, 1, 16'd2, 1'b0, 3, sent);
        check("chg_pkt_cnt", packet_count, 32'd4);

        // ---------------- reset mid-packet while master is stalled ----------------
        do_reset();
        enable        = 1'b1;
        cfg_length    = 16'd4;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = 32'h500;
        M_AXIS_tready = 1'b0;
        tick();
        check("stall_start_tready", 32'(S_AXIS_tready), 32'd1);
        check("stall_start_mvalid", 32'(M_AXIS_tvalid), 32'd0);
        tick();
        check("stall_first_mvalid", 32'(M_AXIS_tvalid), 32'd1);
        check("stall_first_mdata", M_AXIS_tdata, 32'h500);
        check("stall_first_tready", 32'(S_AXIS_tready), 32'd1);
        S_AXIS_tdata = 32'h501;
        tick();
        check("stall_skid_tready", 32'(S_AXIS_tready), 32'd0);
        check("stall_skid_mdata", M_AXIS_tdata, 32'h500);
        tick();
        check("stall_hold_tready", 32'(S_AXIS_tready), 32'd0);
        check("stall_hold_mvalid", 32'(M_AXIS_tvalid), 32'd1);
        check("stall_hold_mdata", M_AXIS_tdata, 32'h500);
        do_reset();
        run_stream(32'h600, 8, 8, 4, 4, 1'b0, -1, -1, 16'd0, 1'b0, 3, sent);
        check("post_rst_pkt_cnt", packet_count, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
